// File: rtl/pc_next_unit.sv
// Program counter with next-PC arbitration (jr > jump > branch > sequential),
// a saturating retired-instruction counter and a RUN/HALT fetch-control FSM.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic             jr,
    input  logic             halt_req,
    input  logic [31:0]      imm_shifted,
    input  logic [25:0]      jump_index,
    input  logic [31:0]      jr_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             mis_q, mis_d;
    logic             halted_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             advance;
    logic [31:0]      br_tgt;
    logic [31:0]      jmp_tgt;

    assign pc_plus4 = pc_q + 32'd4;
    // Offset low bits are not trusted; the target is forced word-aligned.
    assign br_tgt   = (pc_plus4 + imm_shifted) & ~32'h3;
    assign jmp_tgt  = {pc_plus4[31:28], jump_index, 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        advance = 1'b0;
        if (state_q == S_RUN) begin
            if (halt_req) begin
                state_d = S_HALT;
            end else if (stall) begin
                state_d = S_RUN;
            end else if (jr && (jr_addr[1:0] != 2'b00)) begin
                state_d = S_HALT;
                mis_d   = 1'b1;
            end else begin
                advance = 1'b1;
                if (jr)                  pc_d = jr_addr;
                else if (jump)           pc_d = jmp_tgt;
                else if (branch && zero) pc_d = br_tgt;
                else                     pc_d = pc_plus4;
            end
        end
    end

    // Counter sticks at all-ones rather than wrapping.
    assign cnt_d = (advance && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            mis_q    <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mis_q    <= mis_d;
            halted_q <= (state_d == S_HALT);
            cnt_q    <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign misaligned  = mis_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed plus randomized bench for pc_next_unit against a cycle-level reference model.
module tb_pc_next_unit;

    localparam int          CNT_W = 8;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             reset, stall, branch, zero, jump, jr, halt_req;
    logic [31:0]      imm_shifted, jr_addr;
    logic [25:0]      jump_index;
    logic [31:0]      pc, pc_plus4;
    logic             halted, misaligned;
    logic [CNT_W-1:0] instr_count;

    int errs   = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_halt, m_mis;
    int          m_cnt;

    pc_next_unit #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .jr(jr), .halt_req(halt_req), .imm_shifted(imm_shifted),
        .jump_index(jump_index), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
        .halted(halted), .misaligned(misaligned), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, st, br, z, j, rj, h,
                         input logic [31:0] imm, input logic [25:0] idx, input logic [31:0] ja);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (r) begin
            m_pc = RPC; m_halt = 0; m_mis = 0; m_cnt = 0;
        end else if (!m_halt) begin
            if (h) m_halt = 1;
            else if (st) ;
            else if (rj && (ja % 4 != 0)) begin
                m_halt = 1; m_mis = 1;
            end else begin
                if (rj)          m_pc = ja;
                else if (j)      m_pc = (seq & 32'hF000_0000) | (32'(idx) * 4);
                else if (br & z) m_pc = (seq + imm) & 32'hFFFF_FFFC;
                else             m_pc = seq;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end
    endtask

    task automatic step(input logic r, st, br, z, j, rj, h,
                        input logic [31:0] imm, input logic [25:0] idx, input logic [31:0] ja);
        reset = r; stall = st; branch = br; zero = z; jump = j; jr = rj; halt_req = h;
        imm_shifted = imm; jump_index = idx; jr_addr = ja;
        model(r, st, br, z, j, rj, h, imm, idx, ja);
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("halted", 32'(halted), 32'(m_halt));
        chk("misaligned", 32'(misaligned), 32'(m_mis));
        chk("instr_count", 32'(instr_count), 32'(m_cnt));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    endtask

    task automatic jr_to(input logic [31:0] a);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, a);
    endtask

    initial begin
        logic [31:0] cnt_before;
        m_pc = 32'hDEAD_BEEF; m_halt = 0; m_mis = 0; m_cnt = 0;

        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_cnt", 32'(instr_count), 32'h0);
        for (int i = 0; i < 4; i++) idle();
        chk("seq_pc", pc, 32'h10);
        chk("seq_cnt", 32'(instr_count), 32'd4);

        jr_to(32'h100);
        step(0, 0, 1, 1, 0, 0, 0, 32'h28, 26'h0, 32'h0);
        chk("br_taken", pc, 32'h12C);
        jr_to(32'h100);
        step(0, 0, 1, 0, 0, 0, 0, 32'h28, 26'h0, 32'h0);
        chk("br_not_taken", pc, 32'h104);
        jr_to(32'h100);
        step(0, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 26'h0, 32'h0);
        chk("br_loop", pc, 32'h100);
        jr_to(32'h100);
        step(0, 0, 1, 1, 0, 0, 0, 32'h0000_002B, 26'h0, 32'h0);
        chk("br_lowbits", pc, 32'h12C);

        jr_to(32'h1000_0000);
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, 26'h40, 32'h0);
        chk("jump", pc, 32'h1000_0100);
        jr_to(32'h1000_0000);
        step(0, 0, 0, 0, 1, 1, 0, 32'h0, 26'h40, 32'h200);
        chk("jr_prio", pc, 32'h200);

        jr_to(32'hFFFF_FFFC);
        cnt_before = 32'(instr_count);
        idle();
        chk("pc_wrap", pc, 32'h0);
        chk("wrap_cnt", 32'(instr_count), cnt_before + 1);

        jr_to(32'h40);
        cnt_before = 32'(instr_count);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 0, 0, 32'h40, 26'h3, 32'h0);
        chk("stall_pc", pc, 32'h40);
        chk("stall_cnt", 32'(instr_count), cnt_before);

        step(0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h203);
        chk("mis_flag", 32'(misaligned), 32'h1);
        chk("mis_halt", 32'(halted), 32'h1);
        chk("mis_pc", pc, 32'h40);
        step(0, 0, 1, 1, 0, 0, 0, 32'h80, 26'h0, 32'h0);
        step(0, 0, 0, 0, 1, 0, 0, 32'h0, 26'h55, 32'h0);
        chk("halt_frozen", pc, 32'h40);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        chk("halt_rst_h", 32'(halted), 32'h0);
        chk("halt_rst_m", 32'(misaligned), 32'h0);

        // halt_req beats stall
        step(0, 1, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0);
        chk("halt_req", 32'(halted), 32'h1);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);

        // long sequential run to reach counter saturation
        for (int i = 0; i < 260; i++) idle();
        chk("cnt_sat", 32'(instr_count), 32'hFF);

        for (int i = 0; i < 1500; i++) begin
            logic        r, st, br, z, j, rj, h;
            logic [31:0] imm, ja;
            r   = ($urandom_range(99) < (m_halt ? 20 : 2));
            h   = ($urandom_range(99) < 3);
            st  = ($urandom_range(99) < 15);
            rj  = ($urandom_range(99) < 10);
            j   = ($urandom_range(99) < 15);
            br  = ($urandom_range(99) < 40);
            z   = $urandom_range(1);
            imm = {{14{$urandom_range(1) == 1}}, 16'($urandom), 2'b00};
            ja  = $urandom & (($urandom_range(99) < 30) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            step(r, st, br, z, j, rj, h, imm, 26'($urandom), ja);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
